// File: rtl/reg_arb_pkg.sv
// Shared types for the register-bus arbiter: FSM states, owner encoding,
// default bus widths and the owner-selection helper.
package reg_arb_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  // On a tie, round-robin mode hands the bus to whoever was not served last.
  function automatic owner_e pick_owner(input logic pend_a, input logic req_b,
                                        input logic rr_mode, input owner_e last_own);
    owner_e own;
    if (pend_a && req_b) begin
      own = (rr_mode && (last_own == OWN_A)) ? OWN_B : OWN_A;
    end else if (pend_a) begin
      own = OWN_A;
    end else begin
      own = OWN_B;
    end
    return own;
  endfunction

endpackage

// File: rtl/reg_arb_pend_buf.sv
// One-entry holding buffer for port A strobes, which cannot be stalled.
// Holds the command, the pending flag and the sticky overrun flag.
module reg_arb_pend_buf
  import reg_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_read_i,
  input  logic              a_write_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  input  logic              pop_i,
  input  logic              ovr_clr_i,
  output logic              pend_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              overrun_o
);

  logic              pend_q, pend_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ovr_q, ovr_d;
  logic              strobe_s;
  logic              accept_s;
  logic              drop_s;

  assign strobe_s = a_read_i | a_write_i;
  // The slot frees in the same cycle it is granted, so a strobe then still fits.
  assign accept_s = strobe_s & (~pend_q | pop_i);
  assign drop_s   = strobe_s & pend_q & ~pop_i;

  // Next state of the buffered command and flags.
  always_comb begin
    pend_d  = pend_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ovr_d   = ovr_q;
    if (accept_s) begin
      pend_d  = 1'b1;
      we_d    = a_write_i;
      addr_d  = a_addr_i;
      wdata_d = a_wdata_i;
    end else if (pop_i) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    if (drop_s) begin
      ovr_d = 1'b1;
    end else if (ovr_clr_i) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Buffer and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      ovr_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ovr_q   <= ovr_d;
    end
  end

  assign pend_o    = pend_q;
  assign we_o      = we_q;
  assign addr_o    = addr_q;
  assign wdata_o   = wdata_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/reg_bus_arbiter.sv
// Shares one register-file port between port A (SPI strobes) and port B
// (req/gnt). Define REG_ARB_RR_EN for round-robin instead of A-first priority.
module reg_bus_arbiter
  import reg_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  output logic              a_overrun,
  input  logic              a_ovr_clr,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              reg_read,
  output logic              reg_write,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            sel_own_s;
  owner_e            last_own_s;
  logic              start_s;
  logic              pop_a_s;
  logic              pend_a_s;
  logic              buf_we_s;
  logic [ADDR_W-1:0] buf_addr_s;
  logic [DATA_W-1:0] buf_wdata_s;
  logic              reg_read_q, reg_read_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic              b_gnt_q, b_gnt_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;

  reg_arb_pend_buf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_pend_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_read_i  (a_read),
    .a_write_i (a_write),
    .a_addr_i  (a_addr),
    .a_wdata_i (a_wdata),
    .pop_i     (pop_a_s),
    .ovr_clr_i (a_ovr_clr),
    .pend_o    (pend_a_s),
    .we_o      (buf_we_s),
    .addr_o    (buf_addr_s),
    .wdata_o   (buf_wdata_s),
    .overrun_o (a_overrun)
  );

  assign start_s   = (state_q == IDLE) && (pend_a_s || b_req);

`ifdef REG_ARB_RR_EN
  localparam logic RR_MODE = 1'b1;
  owner_e last_own_q;

  // Last-granted master; starts at B so A takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_own_q <= OWN_B;
    end else if (start_s) begin
      last_own_q <= sel_own_s;
    end else begin
      last_own_q <= last_own_q;
    end
  end

  assign last_own_s = last_own_q;
`else
  localparam logic RR_MODE = 1'b0;
  assign last_own_s = OWN_B;
`endif

  assign sel_own_s = pick_owner(pend_a_s, b_req, RR_MODE, last_own_s);

  // Sequencer: one access at a time, outputs computed one cycle ahead.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    pop_a_s     = 1'b0;
    reg_read_d  = 1'b0;
    reg_write_d = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    b_gnt_d     = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    a_rvalid_d  = 1'b0;
    b_rvalid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          owner_d = sel_own_s;
          state_d = ISSUE;
          if (sel_own_s == OWN_A) begin
            pop_a_s     = 1'b1;
            reg_read_d  = ~buf_we_s;
            reg_write_d = buf_we_s;
            reg_addr_d  = buf_addr_s;
            reg_wdata_d = buf_we_s ? buf_wdata_s : reg_wdata_q;
          end else begin
            b_gnt_d     = 1'b1;
            reg_read_d  = ~b_we;
            reg_write_d = b_we;
            reg_addr_d  = b_addr;
            reg_wdata_d = b_we ? b_wdata : reg_wdata_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = reg_read_q ? RDWAIT : IDLE;
      end
      RDWAIT: begin
        state_d = IDLE;
        if (owner_q == OWN_A) begin
          a_rdata_d  = reg_rdata;
          a_rvalid_d = 1'b1;
        end else begin
          b_rdata_d  = reg_rdata;
          b_rvalid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_A;
      reg_read_q  <= 1'b0;
      reg_write_q <= 1'b0;
      reg_addr_q  <= {ADDR_W{1'b0}};
      reg_wdata_q <= {DATA_W{1'b0}};
      b_gnt_q     <= 1'b0;
      a_rdata_q   <= {DATA_W{1'b0}};
      b_rdata_q   <= {DATA_W{1'b0}};
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      reg_read_q  <= reg_read_d;
      reg_write_q <= reg_write_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      b_gnt_q     <= b_gnt_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
    end
  end

  assign reg_read  = reg_read_q;
  assign reg_write = reg_write_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign b_gnt     = b_gnt_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed scoreboard bench for reg_bus_arbiter: expected accesses and read
// returns are queued with their due cycle and checked as the DUT produces them.
module tb_reg_bus_arbiter;

  typedef struct {
    int         cyc;
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic       gnt;
  } acc_t;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } rd_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_read, a_write, a_ovr_clr;
  logic [5:0] a_addr;
  logic [7:0] a_wdata;
  logic [7:0] a_rdata;
  logic       a_rvalid, a_overrun;
  logic       b_req, b_we;
  logic [5:0] b_addr;
  logic [7:0] b_wdata;
  logic       b_gnt;
  logic [7:0] b_rdata;
  logic       b_rvalid;
  logic       reg_read, reg_write;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;

  acc_t acc_q[$];
  rd_t  a_q[$];
  rd_t  b_q[$];
  int   cyc;
  int   checks;
  int   errors;
  int   t0;
  logic gnt_seen;

  reg_bus_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_read    (a_read),
    .a_write   (a_write),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_rdata   (a_rdata),
    .a_rvalid  (a_rvalid),
    .a_overrun (a_overrun),
    .a_ovr_clr (a_ovr_clr),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_gnt     (b_gnt),
    .b_rdata   (b_rdata),
    .b_rvalid  (b_rvalid),
    .reg_read  (reg_read),
    .reg_write (reg_write),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd_val(input logic [5:0] a);
    logic [7:0] v;
    case (a)
      6'h12:   v = 8'h3C;
      6'h01:   v = 8'h77;
      default: v = {2'b10, a} ^ 8'h5A;
    endcase
    return v;
  endfunction

  // Register-file model: read data valid the cycle after reg_read, 0 otherwise.
  always_ff @(posedge clk) begin
    reg_rdata <= reg_read ? rd_val(reg_addr) : 8'h00;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_acc(input int c, input logic we, input logic [5:0] addr,
                          input logic [7:0] wdata, input logic gnt);
    acc_t e;
    e.cyc = c; e.we = we; e.addr = addr; e.wdata = wdata; e.gnt = gnt;
    acc_q.push_back(e);
  endtask

  task automatic push_rd(input logic is_b, input int c, input logic [7:0] d);
    rd_t r;
    r.cyc = c; r.data = d;
    if (is_b) b_q.push_back(r);
    else a_q.push_back(r);
  endtask

  task automatic monitor();
    acc_t e;
    rd_t  r;
    if (reg_read || reg_write) begin
      check("acc_expected", 32'(acc_q.size() != 0), 32'd1);
      if (acc_q.size() != 0) begin
        e = acc_q.pop_front();
        check("acc_cycle", 32'(cyc), 32'(e.cyc));
        check("acc_write", 32'(reg_write), 32'(e.we));
        check("acc_read", 32'(reg_read), 32'(!e.we));
        check("acc_addr", 32'(reg_addr), 32'(e.addr));
        if (e.we) check("acc_wdata", 32'(reg_wdata), 32'(e.wdata));
        check("acc_gnt", 32'(b_gnt), 32'(e.gnt));
      end
    end else begin
      if (acc_q.size() != 0 && acc_q[0].cyc <= cyc) begin
        check("acc_fired", 32'(reg_read | reg_write), 32'd1);
        void'(acc_q.pop_front());
      end
      if (b_gnt) check("gnt_without_access", 32'(b_gnt), 32'd0);
    end
    if (b_gnt) gnt_seen = 1'b1;
    if (a_rvalid) begin
      check("a_rvalid_expected", 32'(a_q.size() != 0), 32'd1);
      if (a_q.size() != 0) begin
        r = a_q.pop_front();
        check("a_rvalid_cycle", 32'(cyc), 32'(r.cyc));
        check("a_rdata", 32'(a_rdata), 32'(r.data));
      end
    end else if (a_q.size() != 0 && a_q[0].cyc <= cyc) begin
      check("a_rvalid_fired", 32'(a_rvalid), 32'd1);
      void'(a_q.pop_front());
    end
    if (b_rvalid) begin
      check("b_rvalid_expected", 32'(b_q.size() != 0), 32'd1);
      if (b_q.size() != 0) begin
        r = b_q.pop_front();
        check("b_rvalid_cycle", 32'(cyc), 32'(r.cyc));
        check("b_rdata", 32'(b_rdata), 32'(r.data));
      end
    end else if (b_q.size() != 0 && b_q[0].cyc <= cyc) begin
      check("b_rvalid_fired", 32'(b_rvalid), 32'd1);
      void'(b_q.pop_front());
    end
  endtask

  // One clock: observe at the falling edge, then move just past the rising edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    if (gnt_seen) begin
      b_req = 1'b0;
      gnt_seen = 1'b0;
    end
  endtask

  task automatic check_zero(input string p);
    check({p, "_reg_read"}, 32'(reg_read), 32'd0);
    check({p, "_reg_write"}, 32'(reg_write), 32'd0);
    check({p, "_reg_addr"}, 32'(reg_addr), 32'd0);
    check({p, "_reg_wdata"}, 32'(reg_wdata), 32'd0);
    check({p, "_b_gnt"}, 32'(b_gnt), 32'd0);
    check({p, "_a_rvalid"}, 32'(a_rvalid), 32'd0);
    check({p, "_b_rvalid"}, 32'(b_rvalid), 32'd0);
    check({p, "_a_rdata"}, 32'(a_rdata), 32'd0);
    check({p, "_b_rdata"}, 32'(b_rdata), 32'd0);
    check({p, "_a_overrun"}, 32'(a_overrun), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; gnt_seen = 1'b0;
    rst_n = 1'b0;
    a_read = 1'b0; a_write = 1'b0; a_addr = 6'h00; a_wdata = 8'h00; a_ovr_clr = 1'b0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 6'h00; b_wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Contention: A write 0x02 and B read 0x01 tie in IDLE; A strobes again meanwhile.
    t0 = cyc;
    a_write = 1'b1; a_addr = 6'h02; a_wdata = 8'h5C;
    push_acc(t0 + 2, 1'b1, 6'h02, 8'h5C, 1'b0);
`ifdef REG_ARB_RR_EN
    push_acc(t0 + 4, 1'b0, 6'h01, 8'h00, 1'b1);
    push_rd(1'b1, t0 + 6, 8'h77);
    push_acc(t0 + 7, 1'b1, 6'h03, 8'h6D, 1'b0);
`else
    push_acc(t0 + 4, 1'b1, 6'h03, 8'h6D, 1'b0);
    push_acc(t0 + 6, 1'b0, 6'h01, 8'h00, 1'b1);
    push_rd(1'b1, t0 + 8, 8'h77);
`endif
    tick();
    a_write = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'h01; b_wdata = 8'hEE;
    tick();
    a_write = 1'b1; a_addr = 6'h03; a_wdata = 8'h6D;
    tick();
    a_write = 1'b0;
    repeat (8) tick();
    check("contention_no_overrun", 32'(a_overrun), 32'd0);

    // Port A write 0x05 <- 0xA5.
    t0 = cyc;
    a_write = 1'b1; a_addr = 6'h05; a_wdata = 8'hA5;
    push_acc(t0 + 2, 1'b1, 6'h05, 8'hA5, 1'b0);
    tick();
    a_write = 1'b0;
    repeat (4) tick();

    // Port A read 0x12 -> 0x3C at T+4.
    t0 = cyc;
    a_read = 1'b1; a_addr = 6'h12;
    push_acc(t0 + 2, 1'b0, 6'h12, 8'h00, 1'b0);
    push_rd(1'b0, t0 + 4, 8'h3C);
    tick();
    a_read = 1'b0;
    repeat (5) tick();
    check("a_rdata_hold", 32'(a_rdata), 32'h3C);

    // Back-to-back A strobes while idle: second loads as the first is granted.
    t0 = cyc;
    a_write = 1'b1; a_addr = 6'h08; a_wdata = 8'h18;
    push_acc(t0 + 2, 1'b1, 6'h08, 8'h18, 1'b0);
    push_acc(t0 + 4, 1'b1, 6'h09, 8'h19, 1'b0);
    tick();
    a_addr = 6'h09; a_wdata = 8'h19;
    tick();
    a_write = 1'b0;
    repeat (4) tick();
    check("b2b_no_overrun", 32'(a_overrun), 32'd0);

    // Port B write 0x2A <- 0x81: strobe and gnt at T+1.
    t0 = cyc;
    b_req = 1'b1; b_we = 1'b1; b_addr = 6'h2A; b_wdata = 8'h81;
    push_acc(t0 + 1, 1'b1, 6'h2A, 8'h81, 1'b1);
    repeat (4) tick();

    // Overrun: B read holds the bus, two A strobes one cycle apart.
    t0 = cyc;
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'h07;
    push_acc(t0 + 1, 1'b0, 6'h07, 8'h00, 1'b1);
    push_rd(1'b1, t0 + 3, rd_val(6'h07));
    push_acc(t0 + 4, 1'b1, 6'h10, 8'h11, 1'b0);
    tick();
    a_write = 1'b1; a_addr = 6'h10; a_wdata = 8'h11;
    tick();
    a_addr = 6'h20; a_wdata = 8'h22;
    tick();
    a_write = 1'b0;
    check("overrun_set", 32'(a_overrun), 32'd1);
    repeat (3) tick();
    check("overrun_sticky", 32'(a_overrun), 32'd1);
    a_ovr_clr = 1'b1;
    tick();
    a_ovr_clr = 1'b0;
    check("overrun_cleared", 32'(a_overrun), 32'd0);
    repeat (3) tick();

    // Reset asserted during ISSUE of a port A read.
    t0 = cyc;
    a_read = 1'b1; a_addr = 6'h12;
    push_acc(t0 + 2, 1'b0, 6'h12, 8'h00, 1'b0);
    tick();
    a_read = 1'b0;
    tick();
    @(negedge clk);
    monitor();
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    @(posedge clk);
    #1;
    cyc++;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();

    // Normal service after reset: B read 0x01.
    t0 = cyc;
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'h01;
    push_acc(t0 + 1, 1'b0, 6'h01, 8'h00, 1'b1);
    push_rd(1'b1, t0 + 3, 8'h77);
    for (int i = 0; i < 20 && (acc_q.size() + a_q.size() + b_q.size()) != 0; i++) tick();
    repeat (2) tick();
    check("acc_queue_drained", 32'(acc_q.size()), 32'd0);
    check("a_queue_drained", 32'(a_q.size()), 32'd0);
    check("b_queue_drained", 32'(b_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
